rv_dmem_arbiter: RTL and testbench

RV_DMEM_ARBITER -- requirements
Module: rv_dmem_arbiter

---
 rtl/rv_dmem_arbiter.sv | 115 +++++++++++
 tb/tb_rv_dmem_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_dmem_arbiter.sv
// Two-requester data-memory arbiter with a one-cycle, in-order response path.
// Define DMEM_ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module rv_dmem_arbiter #(
    parameter int AW = 12
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        r0_valid_i,
    output logic        r0_ready_o,
    input  logic [63:0] r0_addr_i,
    input  logic        r0_we_i,
    input  logic [7:0]  r0_strobe_i,
    input  logic [63:0] r0_wdata_i,
    output logic        r0_rsp_valid_o,
    output logic [63:0] r0_rsp_rdata_o,
    output logic        r0_rsp_err_o,

    input  logic        r1_valid_i,
    output logic        r1_ready_o,
    input  logic [63:0] r1_addr_i,
    input  logic        r1_we_i,
    input  logic [7:0]  r1_strobe_i,
    input  logic [63:0] r1_wdata_i,
    output logic        r1_rsp_valid_o,
    output logic [63:0] r1_rsp_rdata_o,
    output logic        r1_rsp_err_o,

    output logic [63:0] mem_addr_o,
    output logic        mem_wr_en_o,
    output logic [7:0]  mem_wr_strobe_o,
    output logic [63:0] mem_wr_data_o,
    output logic        mem_rd_en_o,
    input  logic [63:0] mem_rd_data_i
);
    logic        acc;
    logic        gnt_id;
    logic        sel_we;
    logic [63:0] sel_addr;
    logic [7:0]  sel_strobe;
    logic [63:0] sel_wdata;
    logic        in_range;
    logic        mem_acc;

    logic        rsp_vld_q, rsp_vld_d;
    logic        rsp_own_q, rsp_own_d;
    logic        rsp_we_q,  rsp_we_d;
    logic        rsp_err_q, rsp_err_d;
    logic        r0_own, r1_own;

    assign acc = (r0_valid_i | r1_valid_i) & ~rst;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
    // last_q holds the most recently granted requester; reset value 1 gives requester 0 priority.
    logic last_q, last_d;

    assign gnt_id = (r0_valid_i & r1_valid_i) ? ~last_q : ~r0_valid_i;
    assign last_d = acc ? gnt_id : last_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) last_q <= 1'b1;
        else     last_q <= last_d;
    end
`else
    assign gnt_id = ~r0_valid_i;
`endif

    assign r0_ready_o = acc & ~gnt_id;
    assign r1_ready_o = acc &  gnt_id;

    assign sel_addr   = gnt_id ? r1_addr_i   : r0_addr_i;
    assign sel_we     = gnt_id ? r1_we_i     : r0_we_i;
    assign sel_strobe = gnt_id ? r1_strobe_i : r0_strobe_i;
    assign sel_wdata  = gnt_id ? r1_wdata_i  : r0_wdata_i;

    assign in_range = (sel_addr >> AW) == 64'd0;
    assign mem_acc  = acc & in_range;

    assign mem_addr_o      = rst ? 64'd0 : sel_addr;
    assign mem_wr_strobe_o = rst ? 8'd0  : sel_strobe;
    assign mem_wr_data_o   = rst ? 64'd0 : sel_wdata;
    assign mem_wr_en_o     = mem_acc &  sel_we;
    assign mem_rd_en_o     = mem_acc & ~sel_we;

    assign rsp_vld_d = acc;
    assign rsp_own_d = gnt_id;
    assign rsp_we_d  = sel_we;
    assign rsp_err_d = ~in_range;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_vld_q <= 1'b0;
            rsp_own_q <= 1'b0;
            rsp_we_q  <= 1'b0;
            rsp_err_q <= 1'b0;
        end else begin
            rsp_vld_q <= rsp_vld_d;
            rsp_own_q <= rsp_own_d;
            rsp_we_q  <= rsp_we_d;
            rsp_err_q <= rsp_err_d;
        end
    end

    // Memory read data arrives in the response cycle and is routed only to the owner of a good read.
    assign r0_own = rsp_vld_q & ~rsp_own_q;
    assign r1_own = rsp_vld_q &  rsp_own_q;

    assign r0_rsp_valid_o = r0_own;
    assign r1_rsp_valid_o = r1_own;
    assign r0_rsp_err_o   = r0_own & rsp_err_q;
    assign r1_rsp_err_o   = r1_own & rsp_err_q;
    assign r0_rsp_rdata_o = (r0_own & ~rsp_we_q & ~rsp_err_q) ? mem_rd_data_i : 64'd0;
    assign r1_rsp_rdata_o = (r1_own & ~rsp_we_q & ~rsp_err_q) ? mem_rd_data_i : 64'd0;

endmodule

// File: tb/tb_rv_dmem_arbiter.sv
// Bench for rv_dmem_arbiter: external memory, spec-level reference model, directed and random traffic.
`timescale 1ns/1ps
module tb_rv_dmem_arbiter;
    localparam int AW = 12;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        r0_valid_i, r0_ready_o, r0_we_i, r0_rsp_valid_o, r0_rsp_err_o;
    logic [63:0] r0_addr_i, r0_wdata_i, r0_rsp_rdata_o;
    logic [7:0]  r0_strobe_i;
    logic        r1_valid_i, r1_ready_o, r1_we_i, r1_rsp_valid_o, r1_rsp_err_o;
    logic [63:0] r1_addr_i, r1_wdata_i, r1_rsp_rdata_o;
    logic [7:0]  r1_strobe_i;
    logic [63:0] mem_addr_o, mem_wr_data_o, mem_rd_data_i;
    logic        mem_wr_en_o, mem_rd_en_o;
    logic [7:0]  mem_wr_strobe_o;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rv_dmem_arbiter #(.AW(AW)) dut (
        .clk(clk), .rst(rst),
        .r0_valid_i(r0_valid_i), .r0_ready_o(r0_ready_o), .r0_addr_i(r0_addr_i), .r0_we_i(r0_we_i),
        .r0_strobe_i(r0_strobe_i), .r0_wdata_i(r0_wdata_i), .r0_rsp_valid_o(r0_rsp_valid_o),
        .r0_rsp_rdata_o(r0_rsp_rdata_o), .r0_rsp_err_o(r0_rsp_err_o),
        .r1_valid_i(r1_valid_i), .r1_ready_o(r1_ready_o), .r1_addr_i(r1_addr_i), .r1_we_i(r1_we_i),
        .r1_strobe_i(r1_strobe_i), .r1_wdata_i(r1_wdata_i), .r1_rsp_valid_o(r1_rsp_valid_o),
        .r1_rsp_rdata_o(r1_rsp_rdata_o), .r1_rsp_err_o(r1_rsp_err_o),
        .mem_addr_o(mem_addr_o), .mem_wr_en_o(mem_wr_en_o), .mem_wr_strobe_o(mem_wr_strobe_o),
        .mem_wr_data_o(mem_wr_data_o), .mem_rd_en_o(mem_rd_en_o), .mem_rd_data_i(mem_rd_data_i)
    );

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b expected=%b t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk64(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] d, input logic [7:0] s);
        logic [63:0] r;
        r = old;
        for (int i = 0; i < 8; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    // External synchronous memory: the op seen before an edge is committed at that edge.
    logic [63:0]   tbmem [0:(1<<AW)-1];
    logic          env_wr, env_rd;
    logic [AW-1:0] env_idx;
    logic [63:0]   env_d;
    logic [7:0]    env_s;
    initial begin
        for (int i = 0; i < (1<<AW); i++) tbmem[i] = 64'd0;
        mem_rd_data_i = 64'd0;
        forever begin
            @(negedge clk);
            env_wr = mem_wr_en_o; env_rd = mem_rd_en_o; env_idx = mem_addr_o[AW-1:0];
            env_d = mem_wr_data_o; env_s = mem_wr_strobe_o;
            @(posedge clk);
            if (env_wr) tbmem[env_idx] = merge(tbmem[env_idx], env_d, env_s);
            if (env_rd) mem_rd_data_i = tbmem[env_idx];
        end
    end

    // Reference model: grant rule, memory contents and the single pending response.
    logic [63:0] ref_mem [0:(1<<AW)-1];
    logic        m_pv, m_pown, m_perr, m_prio;
    logic [63:0] m_prd;
    logic [1:0]  g;
    logic        gwe, gin;
    logic [63:0] ga, gd;
    logic [7:0]  gs;
    initial begin
        for (int i = 0; i < (1<<AW); i++) ref_mem[i] = 64'd0;
        m_pv = 1'b0; m_pown = 1'b0; m_perr = 1'b0; m_prio = 1'b0; m_prd = 64'd0;
        forever begin
            @(negedge clk);
            if (rst) begin
                chk1("rst_r0_ready", r0_ready_o, 1'b0);
                chk1("rst_r1_ready", r1_ready_o, 1'b0);
                chk1("rst_r0_rsp_valid", r0_rsp_valid_o, 1'b0);
                chk1("rst_r1_rsp_valid", r1_rsp_valid_o, 1'b0);
                chk1("rst_r0_rsp_err", r0_rsp_err_o, 1'b0);
                chk1("rst_r1_rsp_err", r1_rsp_err_o, 1'b0);
                chk64("rst_r0_rdata", r0_rsp_rdata_o, 64'd0);
                chk64("rst_r1_rdata", r1_rsp_rdata_o, 64'd0);
                chk1("rst_mem_wr_en", mem_wr_en_o, 1'b0);
                chk1("rst_mem_rd_en", mem_rd_en_o, 1'b0);
                chk64("rst_mem_addr", mem_addr_o, 64'd0);
                chk64("rst_mem_wdata", mem_wr_data_o, 64'd0);
                chk64("rst_mem_strobe", {56'd0, mem_wr_strobe_o}, 64'd0);
                m_pv = 1'b0;
                m_prio = 1'b0;
            end else begin
                chk1("r0_rsp_valid", r0_rsp_valid_o, m_pv && !m_pown);
                chk1("r1_rsp_valid", r1_rsp_valid_o, m_pv && m_pown);
                chk1("r0_rsp_err", r0_rsp_err_o, m_pv && !m_pown && m_perr);
                chk1("r1_rsp_err", r1_rsp_err_o, m_pv && m_pown && m_perr);
                chk64("r0_rsp_rdata", r0_rsp_rdata_o, (m_pv && !m_pown) ? m_prd : 64'd0);
                chk64("r1_rsp_rdata", r1_rsp_rdata_o, (m_pv && m_pown) ? m_prd : 64'd0);

                if (r0_valid_i && r1_valid_i) g = (RR && m_prio) ? 2'd1 : 2'd0;
                else if (r0_valid_i)          g = 2'd0;
                else if (r1_valid_i)          g = 2'd1;
                else                          g = 2'd2;
                ga  = g[0] ? r1_addr_i   : r0_addr_i;
                gwe = g[0] ? r1_we_i     : r0_we_i;
                gs  = g[0] ? r1_strobe_i : r0_strobe_i;
                gd  = g[0] ? r1_wdata_i  : r0_wdata_i;
                gin = (ga >> AW) == 64'd0;

                chk1("r0_ready", r0_ready_o, g == 2'd0);
                chk1("r1_ready", r1_ready_o, g == 2'd1);
                chk1("mem_wr_en", mem_wr_en_o, (g != 2'd2) && gin && gwe);
                chk1("mem_rd_en", mem_rd_en_o, (g != 2'd2) && gin && !gwe);
                if (g != 2'd2 && gin) chk64("mem_addr", mem_addr_o, ga);
                if (g != 2'd2 && gin && gwe) begin
                    chk64("mem_wdata", mem_wr_data_o, gd);
                    chk64("mem_strobe", {56'd0, mem_wr_strobe_o}, {56'd0, gs});
                end

                m_pv = (g != 2'd2);
                if (g != 2'd2) begin
                    m_pown = g[0];
                    m_perr = !gin;
                    m_prd  = (gin && !gwe) ? ref_mem[ga[AW-1:0]] : 64'd0;
                    if (gin && gwe) ref_mem[ga[AW-1:0]] = merge(ref_mem[ga[AW-1:0]], gd, gs);
                    m_prio = (g == 2'd0);
                end
            end
        end
    end

    task automatic drive(input int n, input logic v, input logic we, input logic [63:0] a,
                         input logic [7:0] s, input logic [63:0] d);
        if (n == 0) begin
            r0_valid_i = v; r0_we_i = we; r0_addr_i = a; r0_strobe_i = s; r0_wdata_i = d;
        end else begin
            r1_valid_i = v; r1_we_i = we; r1_addr_i = a; r1_strobe_i = s; r1_wdata_i = d;
        end
    endtask

    // Issue one request alone and collect what the owner sees in the following cycle.
    task automatic do_op(input int n, input logic we, input logic [63:0] a, input logic [7:0] s,
                         input logic [63:0] d, output logic rv, output logic [63:0] rd,
                         output logic re, output logic rden);
        int   t;
        logic got;
        t = 0; got = 1'b0; rden = 1'b0;
        @(posedge clk); #1;
        drive(n, 1'b1, we, a, s, d);
        while (!got && t < 20) begin
            @(negedge clk);
            got  = (n == 0) ? r0_ready_o : r1_ready_o;
            rden = mem_rd_en_o;
            t++;
        end
        chk1("op_accepted", got, 1'b1);
        @(posedge clk); #1;
        drive(n, 1'b0, 1'b0, 64'd0, 8'd0, 64'd0);
        @(negedge clk);
        rv = (n == 0) ? r0_rsp_valid_o : r1_rsp_valid_o;
        rd = (n == 0) ? r0_rsp_rdata_o : r1_rsp_rdata_o;
        re = (n == 0) ? r0_rsp_err_o   : r1_rsp_err_o;
    endtask

    task automatic rnd_req(output logic we, output logic [63:0] a, output logic [7:0] s, output logic [63:0] d);
        int b;
        we = 1'($urandom_range(0, 1));
        a  = 64'($urandom_range(0, 31));
        if ($urandom_range(0, 9) == 0) begin
            b = $urandom_range(AW, 63);
            a[b] = 1'b1;
        end
        s = 8'($urandom);
        d = {$urandom, $urandom};
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish t=%0t", $time);
        $fatal(1, "watchdog");
    end

    logic        rv, re, rden, a0, a1, we;
    logic [63:0] rd, ad, dd;
    logic [7:0]  sd;
    logic [1:0]  gl [4];
    logic [1:0]  eg;

    initial begin
        rst = 1'b1;
        drive(0, 1'b0, 1'b0, 64'd0, 8'd0, 64'd0);
        drive(1, 1'b0, 1'b0, 64'd0, 8'd0, 64'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Contention straight out of reset.
        drive(0, 1'b1, 1'b0, 64'h1, 8'hFF, 64'd0);
        drive(1, 1'b1, 1'b0, 64'h2, 8'hFF, 64'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            gl[i] = r0_ready_o ? 2'd0 : (r1_ready_o ? 2'd1 : 2'd3);
        end
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, 64'd0, 8'd0, 64'd0);
        drive(1, 1'b0, 1'b0, 64'd0, 8'd0, 64'd0);
        for (int i = 0; i < 4; i++) begin
            eg = RR ? 2'(i % 2) : 2'd0;
            chk64("contention_grant", {62'd0, gl[i]}, {62'd0, eg});
        end

        do_op(0, 1'b1, 64'h10, 8'hFF, 64'hDEADBEEF_CAFEF00D, rv, rd, re, rden);
        chk1("wr_ack_valid", rv, 1'b1);
        chk1("wr_ack_err", re, 1'b0);
        chk64("wr_ack_rdata", rd, 64'd0);
        do_op(0, 1'b0, 64'h10, 8'h00, 64'd0, rv, rd, re, rden);
        chk1("rd_valid", rv, 1'b1);
        chk64("rd_after_wr", rd, 64'hDEADBEEF_CAFEF00D);

        do_op(0, 1'b1, 64'h20, 8'hFF, 64'hFFFFFFFF_FFFFFFFF, rv, rd, re, rden);
        do_op(0, 1'b1, 64'h20, 8'h0F, 64'h11223344_55667788, rv, rd, re, rden);
        do_op(0, 1'b0, 64'h20, 8'h00, 64'd0, rv, rd, re, rden);
        chk64("partial_wr_readback", rd, 64'hFFFFFFFF_55667788);

        do_op(1, 1'b0, 64'h1000, 8'h00, 64'd0, rv, rd, re, rden);
        chk1("oor_no_mem_rd", rden, 1'b0);
        chk1("oor_rsp_valid", rv, 1'b1);
        chk1("oor_rsp_err", re, 1'b1);
        chk64("oor_rdata", rd, 64'd0);

        // Reset in the response cycle of a read.
        @(posedge clk); #1;
        drive(0, 1'b1, 1'b0, 64'h10, 8'h00, 64'd0);
        @(negedge clk);
        chk1("pre_rst_accept", r0_ready_o, 1'b1);
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, 64'd0, 8'd0, 64'd0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk1("post_rst_no_rsp_r0", r0_rsp_valid_o, 1'b0);
            chk1("post_rst_no_rsp_r1", r1_rsp_valid_o, 1'b0);
        end
        @(posedge clk); #1;
        drive(0, 1'b1, 1'b0, 64'h3, 8'h00, 64'd0);
        drive(1, 1'b1, 1'b0, 64'h4, 8'h00, 64'd0);
        @(negedge clk);
        chk1("post_rst_grant_r0", r0_ready_o, 1'b1);
        chk1("post_rst_r1_waits", r1_ready_o, 1'b0);
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, 64'd0, 8'd0, 64'd0);
        drive(1, 1'b0, 1'b0, 64'd0, 8'd0, 64'd0);

        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            a0 = r0_valid_i && r0_ready_o;
            a1 = r1_valid_i && r1_ready_o;
            @(posedge clk); #1;
            if (c == 1500) rst = 1'b1;
            if (c == 1503) rst = 1'b0;
            if (!r0_valid_i || a0) begin
                if ($urandom_range(0, 99) < 60) begin
                    rnd_req(we, ad, sd, dd);
                    drive(0, 1'b1, we, ad, sd, dd);
                end else drive(0, 1'b0, 1'b0, 64'd0, 8'd0, 64'd0);
            end
            if (!r1_valid_i || a1) begin
                if ($urandom_range(0, 99) < 60) begin
                    rnd_req(we, ad, sd, dd);
                    drive(1, 1'b1, we, ad, sd, dd);
                end else drive(1, 1'b0, 1'b0, 64'd0, 8'd0, 64'd0);
            end
        end
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, 64'd0, 8'd0, 64'd0);
        drive(1, 1'b0, 1'b0, 64'd0, 8'd0, 64'd0);
        repeat (3) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
